// File: rtl/q_learn_pkg.sv
// Shared defaults, types and helpers for the Q-learning value update pipeline.
package q_learn_pkg;

   localparam int W_DEF           = 16;
   localparam int ADDR_W_DEF      = 8;
   localparam int CNT_W_DEF       = 16;
   localparam int GAMMA_TERMS_DEF = 3;
   // Bit i-1 set adds max_q >>> i to the discounted term: 0.5+0.25+0.125 = 0.875.
   localparam logic [GAMMA_TERMS_DEF-1:0] GAMMA_MASK_DEF = 3'b111;

   // Widest data width the helpers accept; callers sign-extend into this.
   localparam int MAX_W   = 32;
   localparam int SHIFT_W = 4;

   // Saturation verdict for a wide intermediate squeezed into w bits.
   typedef struct packed {
      logic sat;   // value lies outside the signed w-bit range
      logic neg;   // direction of the clip (1 = clip to most negative)
   } sat_info_t;

   // Classifies a sign-extended update against the signed w-bit range; the caller
   // picks the clipped or truncated w-bit value from the verdict.
   function automatic sat_info_t sat_to_w(input logic signed [MAX_W+2:0] v,
                                          input int unsigned            w);
      logic signed [MAX_W+2:0] one;
      logic signed [MAX_W+2:0] hi;
      logic signed [MAX_W+2:0] lo;
      sat_info_t               r;
      one   = {{(MAX_W+2){1'b0}}, 1'b1};
      hi    = (one <<< (w - 1)) - one;
      lo    = ~hi;
      r.sat = (v > hi) || (v < lo);
      r.neg = v[MAX_W+2];
      return r;
   endfunction

   // Shifting by w or more would throw away the whole term, so cap at w-1.
   function automatic logic [SHIFT_W-1:0] clamp_alpha(input logic [SHIFT_W-1:0] s,
                                                      input int unsigned        w);
      if (32'(s) >= w) return SHIFT_W'(w - 1);
      return s;
   endfunction

endpackage

// File: rtl/q_update_pipe_discount.sv
// Combinational gamma*max_q built from arithmetic right shifts selected by a mask.
module q_discount
   import q_learn_pkg::*;
#(
   parameter int                     W           = W_DEF,
   parameter int                     GAMMA_TERMS = GAMMA_TERMS_DEF,
   parameter logic [GAMMA_TERMS-1:0] GAMMA_MASK  = GAMMA_MASK_DEF
) (
   input  logic [W-1:0] max_q,
   output logic [W:0]   disc
);

   logic signed [W:0] max_ext;
   logic signed [W:0] acc;

   assign max_ext = {max_q[W-1], max_q};

   // Sum the enabled binary fractions of max_q.
   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      acc = '0;
      for (int i = 1; i <= GAMMA_TERMS; i++) begin
         if (GAMMA_MASK[i-1]) acc = acc + (max_ext >>> i);
      end
   end

   assign disc = acc;

endmodule

// File: rtl/q_update_pipe.sv
// Three-stage Q-value updater: new_q = old_q + alpha*(reward + gamma*max_q - old_q),
// saturated to W bits, with valid/ready on both sides and a pass-through address tag.
module q_update_pipe
   import q_learn_pkg::*;
#(
   parameter int                     W           = W_DEF,
   parameter int                     ADDR_W      = ADDR_W_DEF,
   parameter int                     GAMMA_TERMS = GAMMA_TERMS_DEF,
   parameter logic [GAMMA_TERMS-1:0] GAMMA_MASK  = GAMMA_MASK_DEF,
   parameter int                     CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_old_q,
   input  logic [W-1:0]      in_max_q,
   input  logic [W-1:0]      in_reward,
   input  logic [3:0]        in_alpha_shift,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_new_q,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_sat,
   output logic [CNT_W-1:0]  sat_count
);

   localparam int XW = W + 3;   // headroom for reward + disc - old_q and the final add

   // Global pipeline enable: everything moves when the output slot is free or draining.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Stage 1 registers
   logic                 s1_valid;
   logic signed [W:0]    s1_disc;
   logic signed [W-1:0]  s1_old;
   logic signed [W-1:0]  s1_reward;
   logic [3:0]           s1_ashift;
   logic [ADDR_W-1:0]    s1_addr;

   // Stage 2 registers
   logic                 s2_valid;
   logic signed [XW-1:0] s2_td;
   logic signed [W-1:0]  s2_old;
   logic [3:0]           s2_ashift;
   logic [ADDR_W-1:0]    s2_addr;

   logic [W:0]           disc_c;
   logic signed [XW-1:0] td_c;
   logic signed [XW-1:0] upd_c;
   sat_info_t            sat_c;
   logic [W-1:0]         q_c;

   q_discount #(
      .W           (W),
      .GAMMA_TERMS (GAMMA_TERMS),
      .GAMMA_MASK  (GAMMA_MASK)
   ) u_discount (
      .max_q (in_max_q),
      .disc  (disc_c)
   );

   // Temporal difference from stage-1 operands; W+3 bits cannot overflow.
   always_comb begin
      td_c = XW'(s1_reward) + XW'(s1_disc) - XW'(s1_old);
   end

   // Apply alpha as an arithmetic shift, then clip the sum into W bits.
   always_comb begin
      upd_c = XW'(s2_old) + (s2_td >>> s2_ashift);
      sat_c = sat_to_w((MAX_W+3)'(upd_c), W);
      if (sat_c.sat) q_c = sat_c.neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else           q_c = upd_c[W-1:0];
   end

   // Stage valids and the visible output register; cleared by reset.
   // NOTE: sequential state uses non-blocking assignments so all stages sample the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_new_q <= '0;
         out_addr  <= '0;
         out_sat   <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         out_new_q <= q_c;
         out_addr  <= s2_addr;
         out_sat   <= s2_valid && sat_c.sat;
      end
   end

   // Internal data payload of stages 1 and 2, qualified by the stage valids.
   // NOTE: payload registers have no reset; their valid bits already mark them as empty.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_disc   <= $signed(disc_c);
         s1_old    <= $signed(in_old_q);
         s1_reward <= $signed(in_reward);
         s1_ashift <= clamp_alpha(in_alpha_shift, W);
         s1_addr   <= in_addr;
         s2_td     <= td_c;
         s2_old    <= s1_old;
         s2_ashift <= s1_ashift;
         s2_addr   <= s1_addr;
      end
   end

   // Count delivered saturated results, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && out_sat && (sat_count != '1)) begin
         sat_count <= sat_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_q_update_pipe.sv
// Randomised and directed bench for q_update_pipe with an arithmetic reference model
// and an in-order scoreboard driven from observed handshakes.
module tb_q_update_pipe;
   import q_learn_pkg::*;

   localparam int W      = 16;
   localparam int ADDR_W = 8;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_old_q;
   logic [W-1:0]      in_max_q;
   logic [W-1:0]      in_reward;
   logic [3:0]        in_alpha_shift;
   logic [ADDR_W-1:0] in_addr;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_new_q;
   logic [ADDR_W-1:0] out_addr;
   logic              out_sat;
   logic [CNT_W-1:0]  sat_count;

   q_update_pipe #(.W(W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_old_q       (in_old_q),
      .in_max_q       (in_max_q),
      .in_reward      (in_reward),
      .in_alpha_shift (in_alpha_shift),
      .in_addr        (in_addr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_new_q      (out_new_q),
      .out_addr       (out_addr),
      .out_sat        (out_sat),
      .sat_count      (sat_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int q;
      int addr;
      bit sat;
   } exp_t;

   exp_t              exp_q[$];
   int                n_cmp     = 0;
   int                n_bad     = 0;
   int                sat_model = 0;
   int                delivered = 0;
   bit                stall_prev = 1'b0;
   logic [W-1:0]      held_q;
   logic [ADDR_W-1:0] held_addr;
   logic              held_sat;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: gamma*max_q as a sum of halvings, alpha as a power-of-two divide, clip.
   function automatic void ref_update(input int old_q, input int max_q, input int reward,
                                      input int ash, output int q, output bit sat);
      int disc;
      int td;
      int sh;
      int upd;
      int hi;
      int lo;
      disc = 0;
      for (int i = 1; i <= GAMMA_TERMS_DEF; i++)
         if (GAMMA_MASK_DEF[i-1]) disc += max_q >>> i;
      td  = reward + disc - old_q;
      sh  = (ash >= W) ? W - 1 : ash;
      upd = old_q + (td >>> sh);
      hi  = (1 << (W - 1)) - 1;
      lo  = -(1 << (W - 1));
      sat = 1'b0;
      q   = upd;
      if (upd > hi) begin q = hi; sat = 1'b1; end
      else if (upd < lo) begin q = lo; sat = 1'b1; end
   endfunction

   // Monitor: sample both handshakes mid-cycle, score outputs, enqueue accepted inputs.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         sat_model  = 0;
         stall_prev = 1'b0;
      end else begin
         check("sat_count", sat_count, sat_model);
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_q", out_new_q, held_q);
            check("hold_addr", out_addr, held_addr);
            check("hold_sat", out_sat, held_sat);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("new_q", $signed(out_new_q), e.q);
               check("addr", out_addr, e.addr);
               check("sat", out_sat, e.sat);
               if (e.sat && sat_model < (1 << CNT_W) - 1) sat_model++;
               delivered++;
            end
         end
         if (in_valid && in_ready) begin
            ref_update(int'($signed(in_old_q)), int'($signed(in_max_q)),
                       int'($signed(in_reward)), int'(in_alpha_shift), e.q, e.sat);
            e.addr = int'(in_addr);
            exp_q.push_back(e);
         end
         stall_prev = out_valid && !out_ready;
         held_q     = out_new_q;
         held_addr  = out_addr;
         held_sat   = out_sat;
      end
   end

   task automatic drive_in(input int old_q, input int max_q, input int reward,
                           input int ash, input int addr);
      in_old_q       = old_q[W-1:0];
      in_max_q       = max_q[W-1:0];
      in_reward      = reward[W-1:0];
      in_alpha_shift = ash[3:0];
      in_addr        = addr[ADDR_W-1:0];
   endtask

   function automatic int rnd_val();
      case ($urandom_range(0, 7))
         0:       return (1 << (W - 1)) - 1;
         1:       return -(1 << (W - 1));
         2:       return 0;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   // Single transaction on an empty pipe with constant expectations and latency.
   task automatic send_expect(input string tag, input int old_q, input int max_q,
                              input int reward, input int ash, input int addr,
                              input int exp_new_q, input int exp_sat, input int exp_cnt);
      int lat;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive_in(old_q, max_q, reward, ash, addr);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, 3);
      check({tag, "_q"}, $signed(out_new_q), exp_new_q);
      check({tag, "_sat"}, out_sat, exp_sat);
      check({tag, "_addr"}, out_addr, addr);
      @(posedge clk); #1;
      check({tag, "_count"}, sat_count, exp_cnt);
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   // Eight back-to-back inputs, optionally with the output stalled in cycles 4..7.
   task automatic stream(input bit bp);
      int so[8];
      int sm[8];
      int sr[8];
      int sa[8];
      int idx;
      int base;
      for (int k = 0; k < 8; k++) begin
         so[k] = rnd_val();
         sm[k] = rnd_val();
         sr[k] = rnd_val();
         sa[k] = $urandom_range(0, 15);
      end
      base = delivered;
      idx  = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         out_ready = !(bp && c >= 4 && c <= 7);
         if (idx < 8) begin
            drive_in(so[idx], sm[idx], sr[idx], sa[idx], (bp ? 8'h80 : 8'h40) + idx);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (!bp) check("stream_out_valid", out_valid, (c >= 3 && c < 11));
         else     check("bp_in_ready", in_ready, !(c >= 4 && c <= 7));
         if (in_valid && in_ready) idx++;
      end
      drain();
      check(bp ? "bp_delivered" : "stream_delivered", delivered - base, 8);
   endtask

   initial begin
      bit pend;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive_in(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sat_count", sat_count, 0);
      check("rst_new_q", out_new_q, 0);
      check("rst_addr", out_addr, 0);
      check("rst_sat", out_sat, 0);

      send_expect("basic", 0, 64, 16, 1, 8'h11, 36, 0, 0);
      send_expect("neg_a", 100, 0, -100, 1, 8'h12, 0, 0, 0);
      send_expect("neg_b", -50, -64, 0, 0, 8'h13, -56, 0, 0);
      send_expect("sat_pos", 32767, 32767, 32767, 0, 8'h14, 32767, 1, 1);
      send_expect("sat_neg", -32768, -32768, -32768, 0, 8'h15, -32768, 1, 2);
      send_expect("clamp", 0, 0, 32767, 15, 8'h16, 0, 0, 2);

      stream(1'b0);
      stream(1'b1);

      // Random traffic with random backpressure; inputs held until accepted.
      pend = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            drive_in(rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 15),
                     $urandom_range(0, 255));
            in_valid = $urandom_range(0, 1);
            pend     = in_valid;
         end
         #1;
         if (in_valid && in_ready) pend = 1'b0;
      end
      drain();

      // Reset with three transactions in flight.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         drive_in(rnd_val(), rnd_val(), rnd_val(), 0, 8'hA0 + c);
         in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_inflight", out_valid, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mid_out_valid", out_valid, 0);
      check("mid_sat_count", sat_count, 0);
      check("mid_in_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         check("mid_no_ghost", out_valid, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
